// File: rtl/imm_arith_exec_ctrl_pkg.sv
// Shared types for the RV32I immediate-arithmetic execution controller.
// Holds the decoded operation kinds, the controller state encoding and the shift-count width.
package imm_arith_exec_ctrl_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        iak_invalid,
        iak_addi,
        iak_slti,
        iak_sltiu,
        iak_xori,
        iak_ori,
        iak_andi,
        iak_slli,
        iak_srli,
        iak_srai
    } imm_arith_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } imm_arith_ctrl_state_t;

    function automatic logic isShiftKind(input imm_arith_kind_t kind);
        return (kind == iak_slli) || (kind == iak_srli) || (kind == iak_srai);
    endfunction

endpackage

// File: rtl/imm_arith_exec_ctrl_shift_step.sv
// One step of the iterative shifter: shifts a value by a small amount.
// The amount never exceeds SHIFT_STEP, so the shifter stays narrow.
module imm_arith_shift_step
    import imm_arith_exec_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AMT_W = 1
) (
    input  logic [XLEN-1:0]  value_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             left_i,
    input  logic             arith_i,
    output logic [XLEN-1:0]  result_o
);

    // Arithmetic right shifts keep replicating the current MSB, which is still the original sign bit.
    always_comb begin
        if (left_i) begin
            result_o = value_i << amt_i;
        end else if (arith_i) begin
            result_o = $unsigned($signed(value_i) >>> amt_i);
        end else begin
            result_o = value_i >> amt_i;
        end
    end

endmodule

// File: rtl/imm_arith_exec_ctrl.sv
// Execution controller for RV32I immediate-arithmetic instructions.
// Single-cycle ALU ops plus multi-cycle shifts through a narrow iterative shifter.
module imm_arith_exec_ctrl
    import imm_arith_exec_ctrl_pkg::*;
#(
    parameter int SHIFT_STEP = 1,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  imm_arith_kind_t in_kind_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [11:0]     in_imm_i,
    input  logic [4:0]      in_rd_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_result_o,
    output logic [4:0]      out_rd_o,
    output logic            out_illegal_o,
    output logic            busy_o
);

    localparam int STEP_W = $clog2(SHIFT_STEP + 1);

    imm_arith_ctrl_state_t state_q, state_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [4:0]         rd_q, rd_d;
    logic               illegal_q, illegal_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;

    logic               accept;
    logic [XLEN-1:0]    simm;
    logic [XLEN-1:0]    aluResult;
    logic [SHAMT_W-1:0] stepFull;
    logic [STEP_W-1:0]  stepAmt;
    logic [XLEN-1:0]    shiftedVal;

    assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign simm       = {{(XLEN-12){in_imm_i[11]}}, in_imm_i};

    assign stepFull = (rem_q < SHAMT_W'(SHIFT_STEP)) ? rem_q : SHAMT_W'(SHIFT_STEP);
    assign stepAmt  = stepFull[STEP_W-1:0];

    imm_arith_shift_step #(
        .XLEN  (XLEN),
        .AMT_W (STEP_W)
    ) u_shift_step (
        .value_i  (acc_q),
        .amt_i    (stepAmt),
        .left_i   (left_q),
        .arith_i  (arith_q),
        .result_o (shiftedVal)
    );

    // Single-cycle ALU; sltiu deliberately compares against the sign-extended immediate.
    always_comb begin
        aluResult = '0;
        unique case (in_kind_i)
            iak_addi:  aluResult = in_rs1_i + simm;
            iak_slti:  aluResult = {{(XLEN-1){1'b0}}, ($signed(in_rs1_i) < $signed(simm))};
            iak_sltiu: aluResult = {{(XLEN-1){1'b0}}, (in_rs1_i < simm)};
            iak_xori:  aluResult = in_rs1_i ^ simm;
            iak_ori:   aluResult = in_rs1_i | simm;
            iak_andi:  aluResult = in_rs1_i & simm;
            default:   aluResult = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result_d  = result_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        left_d    = left_q;
        arith_d   = arith_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    rd_d      = in_rd_i;
                    illegal_d = (in_kind_i == iak_invalid);
                    left_d    = (in_kind_i == iak_slli);
                    arith_d   = (in_kind_i == iak_srai);
                    if (isShiftKind(in_kind_i)) begin
                        acc_d = in_rs1_i;
                        rem_d = in_imm_i[SHAMT_W-1:0];
                        if (in_imm_i[SHAMT_W-1:0] == '0) begin
                            result_d = in_rs1_i;
                            state_d  = DONE;
                        end else begin
                            state_d  = SHIFT;
                        end
                    end else begin
                        result_d = aluResult;
                        state_d  = DONE;
                    end
                end else if ((state_q == DONE) && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = shiftedVal;
                rem_d = rem_q - stepFull;
                if (rem_q == stepFull) begin
                    result_d = shiftedVal;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            left_q    <= left_d;
            arith_q   <= arith_d;
        end
    end

    assign out_valid_o   = (state_q == DONE);
    assign out_result_o  = result_q;
    assign out_rd_o      = rd_q;
    assign out_illegal_o = illegal_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_imm_arith_exec_ctrl.sv
// Directed testbench for imm_arith_exec_ctrl with two instances (SHIFT_STEP 1 and 4).
// Expected values are hand-computed from the RV32I semantics.
module tb_imm_arith_exec_ctrl;
    import imm_arith_exec_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            inValid1, inValid4, outReady1, outReady4;
    imm_arith_kind_t inKind;
    logic [31:0]     inRs1;
    logic [11:0]     inImm;
    logic [4:0]      inRd;

    logic        inReady1, outValid1, outIllegal1, busy1;
    logic [31:0] outResult1;
    logic [4:0]  outRd1;
    logic        inReady4, outValid4, outIllegal4, busy4;
    logic [31:0] outResult4;
    logic [4:0]  outRd4;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    imm_arith_exec_ctrl #(.SHIFT_STEP(1), .XLEN(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid_i(inValid1), .in_ready_o(inReady1),
        .in_kind_i(inKind), .in_rs1_i(inRs1), .in_imm_i(inImm), .in_rd_i(inRd),
        .out_valid_o(outValid1), .out_ready_i(outReady1),
        .out_result_o(outResult1), .out_rd_o(outRd1),
        .out_illegal_o(outIllegal1), .busy_o(busy1)
    );

    imm_arith_exec_ctrl #(.SHIFT_STEP(4), .XLEN(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid_i(inValid4), .in_ready_o(inReady4),
        .in_kind_i(inKind), .in_rs1_i(inRs1), .in_imm_i(inImm), .in_rd_i(inRd),
        .out_valid_o(outValid4), .out_ready_i(outReady4),
        .out_result_o(outResult4), .out_rd_o(outRd4),
        .out_illegal_o(outIllegal4), .busy_o(busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request at a negedge; returns at the negedge after the accept edge.
    task automatic applyStimulus(input bit useFour, input imm_arith_kind_t kind,
                                 input logic [31:0] rs1, input logic [11:0] imm, input logic [4:0] rd);
        inKind = kind;
        inRs1  = rs1;
        inImm  = imm;
        inRd   = rd;
        if (useFour) inValid4 = 1'b1;
        else         inValid1 = 1'b1;
        #1;
        checkOutput("in_ready_at_issue", {31'b0, (useFour ? inReady4 : inReady1)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid1 = 1'b0;
        inValid4 = 1'b0;
        inKind   = iak_addi;
        inRs1    = 32'hDEADBEEF;
        inImm    = 12'h7A5;
        inRd     = 5'd31;
    endtask

    task automatic waitResult(input bit useFour, output int lat);
        lat = 1;
        while ((useFour ? outValid4 : outValid1) !== 1'b1 && lat < 64) begin
            checkOutput("in_ready_while_busy", {31'b0, (useFour ? inReady4 : inReady1)}, 32'd0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input bit useFour, input imm_arith_kind_t kind,
                         input logic [31:0] rs1, input logic [11:0] imm, input logic [4:0] rd,
                         input logic [31:0] expResult, input int expLat);
        int lat;
        applyStimulus(useFour, kind, rs1, imm, rd);
        waitResult(useFour, lat);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_result"}, useFour ? outResult4 : outResult1, expResult);
        checkOutput({tag, "_rd"}, {27'b0, (useFour ? outRd4 : outRd1)}, {27'b0, rd});
        checkOutput({tag, "_illegal"}, {31'b0, (useFour ? outIllegal4 : outIllegal1)},
                    {31'b0, (kind == iak_invalid)});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rises;
        inValid1  = 1'b0;
        inValid4  = 1'b0;
        outReady1 = 1'b1;
        outReady4 = 1'b1;
        inKind    = iak_addi;
        inRs1     = '0;
        inImm     = '0;
        inRd      = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", {31'b0, outValid1}, 32'd0);
        checkOutput("rst_out_result", outResult1, 32'd0);
        checkOutput("rst_out_rd", {27'b0, outRd1}, 32'd0);
        checkOutput("rst_out_illegal", {31'b0, outIllegal1}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy1}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, inReady1}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        runOp("addi_wrap",   1'b0, iak_addi,  32'h7FFFFFFF, 12'h001, 5'd7,  32'h80000000, 1);
        runOp("sltiu_neg",   1'b0, iak_sltiu, 32'h00000005, 12'hFFF, 5'd8,  32'h00000001, 1);
        runOp("slti_neg",    1'b0, iak_slti,  32'h00000005, 12'hFFF, 5'd9,  32'h00000000, 1);
        runOp("xori_sext",   1'b0, iak_xori,  32'h0000FFFF, 12'h800, 5'd0,  32'hFFFF07FF, 1);

        runOp("srai_s1",     1'b0, iak_srai,  32'h80000010, 12'h404, 5'd10, 32'hF8000001, 5);
        runOp("srli_s1",     1'b0, iak_srli,  32'h80000001, 12'h001, 5'd11, 32'h40000000, 2);
        runOp("srai_shamt0", 1'b0, iak_srai,  32'h80000010, 12'h400, 5'd12, 32'h80000010, 1);
        runOp("srai_s4",     1'b1, iak_srai,  32'h80000010, 12'h404, 5'd13, 32'hF8000001, 2);
        runOp("srai_s4_r5",  1'b1, iak_srai,  32'h80000010, 12'h405, 5'd14, 32'hFC000000, 3);
        runOp("slli_s4_31",  1'b1, iak_slli,  32'h00000003, 12'h01F, 5'd15, 32'h80000000, 9);

        outReady1 = 1'b0;
        runOp("andi_hold",   1'b0, iak_andi,  32'h12345678, 12'h0FF, 5'd9,  32'h00000078, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'b0, outValid1}, 32'd1);
            checkOutput("hold_result", outResult1, 32'h00000078);
            checkOutput("hold_in_ready", {31'b0, inReady1}, 32'd0);
        end
        outReady1 = 1'b1;
        runOp("ori_b2b",     1'b0, iak_ori,   32'h000000F0, 12'h00F, 5'd3,  32'h000000FF, 1);

        runOp("invalid",     1'b0, iak_invalid, 32'h00000055, 12'h123, 5'd2, 32'h00000000, 1);
        runOp("after_inv",   1'b0, iak_addi,  32'h00000001, 12'hFFF, 5'd4,  32'h00000000, 1);

        applyStimulus(1'b0, iak_slli, 32'h00000001, 12'h01F, 5'd5);
        repeat (4) @(negedge clk);
        checkOutput("mid_shift_busy", {31'b0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'b0, outValid1}, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy1}, 32'd0);
        checkOutput("mid_rst_result", outResult1, 32'd0);
        checkOutput("mid_rst_rd", {27'b0, outRd1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'b0, inReady1}, 32'd1);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid1 === 1'b1) rises++;
        end
        checkOutput("no_stale_result", rises, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/imm_arith_exec_ctrl.md
Name: imm_arith_exec_ctrl

Overview:
- Execution controller for RV32I immediate-arithmetic instructions.
- Sits after the immediate-arithmetic decoder. Takes the decoded imm_arith_kind_t, rs1 value, 12-bit immediate and rd.
- Completes non-shift ops in one cycle.
- Sequences slli/srli/srai over multiple cycles through a narrow iterative shifter. Does not use a full barrel shifter.
- Valid/ready handshake on both sides. One instruction in flight.

Parameters:
- SHIFT_STEP, 1: maximum bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4, 8, 16.
- XLEN, 32: datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_kind  in  imm_arith_kind_t  decoded operation
- in_rs1  in  XLEN  source operand
- in_imm  in  12  I-type immediate, raw
- in_rd  in  5  destination register index
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result value
- out_rd  out  5  destination index of the result
- out_illegal  out  1  request kind was iak_invalid
- busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous on rst high.
  - state=IDLE; out_valid=0, out_result=0, out_rd=0, out_illegal=0, busy=0.
  - Internal accumulator and shift count are cleared to 0.
  - Reset mid-operation discards the instruction. No output is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- Accept happens when in_valid && in_ready. On accept:
  - rd is latched.
  - simm = sign-extend(in_imm) to 32 bits.
  - shamt = in_imm[4:0]. Upper immediate bits are ignored for shifts, because funct7 was already checked by the decoder.
- Non-shift kinds: result is registered in the accept cycle. Next state is DONE, so latency is 1.
  - addi: rs1+simm, wraps mod 2^32.
  - slti: signed(rs1) < signed(simm), zero-extended to 32 bits.
  - sltiu: rs1 < simm as unsigned. The comparison uses the sign-extended immediate.
  - xori, ori, andi: bitwise with simm.
- iak_invalid: out_illegal=1, out_result=0, next state DONE.
- Shift kinds:
  - The accumulator loads rs1 and the remaining count loads shamt.
  - If shamt==0: go to DONE with result=rs1, latency 1.
  - Otherwise go to SHIFT. Each SHIFT cycle shifts by s=min(SHIFT_STEP, remaining) and decrements remaining by s.
  - srai fills with the original sign bit. srli and slli fill with zeros.
  - When remaining reaches 0: result = accumulator, go to DONE.
  - Total latency from accept to out_valid is 1+ceil(shamt/SHIFT_STEP) cycles.
- DONE: out_valid=1.
  - out_result, out_rd and out_illegal stay stable until out_ready.
  - When out_ready is high with no new accept: go to IDLE and out_valid drops next cycle.
  - When out_ready is high together with a new accept: the new request is processed as from IDLE in the same cycle. out_valid stays 1 only if the new op is single-cycle.
- in_ready is 0 throughout SHIFT, including the cycle remaining hits 0.
- Inputs are sampled only on accept. Changes to inputs while not accepted have no effect.
- rd=0 is computed normally. Discarding x0 writes is the writeback stage's job.
- out_illegal is cleared on every accept of a legal kind.

Decomposition:
- opcode_type package:
  - imm_arith_kind_t, already present.
  - Add the state enum imm_arith_ctrl_state_t {IDLE, SHIFT, DONE}.
  - Add constant SHAMT_W=5.
- Sub-module imm_arith_shift_step: combinational.
  - Inputs: value, step amount (up to SHIFT_STEP), direction, arithmetic flag.
  - Output: shifted value.
  - Instantiated once, in the SHIFT datapath.
- The ALU for non-shift ops stays inline in the controller.

Test Plan:
- addi, rs1=0x7FFFFFFF, imm=0x001 -> out_result 0x80000000 one cycle after accept, out_rd echoed, out_illegal 0.
- sltiu, rs1=5, imm=0xFFF (simm 0xFFFFFFFF) -> 1. slti with the same operands -> 0.
- SHIFT_STEP=1, srai, rs1=0x80000010, imm[4:0]=4 -> out_result 0xF8000001, out_valid 5 cycles after accept, in_ready 0 in between. Repeat with SHIFT_STEP=4 -> 2 cycles. Repeat with shamt=0 -> rs1 unchanged after 1 cycle.
- Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready 0. Then out_ready=1 with in_valid=1 (ori, rs1=0xF0, imm=0x00F) -> next cycle out_result 0xFF with no bubble.
- in_kind=iak_invalid -> out_illegal 1, out_result 0. Next legal op clears out_illegal.
- Assert rst during SHIFT (slli, shamt 31) -> out_valid 0 immediately, state IDLE, in_ready 1 after release, no stale result.
